// File: rtl/alarm_time_keeper.sv
// Alarm-clock time base: a prescaled wrapping time counter plus a key-entry
// state machine that loads either the running time or the stored alarm value.
module alarm_time_keeper #(
    parameter int WIDTH         = 4,
    parameter int MAX_COUNT     = 9,
    parameter int PRESCALE      = 4,
    parameter int ENTRY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_time,
    input  logic             set_alarm,
    input  logic             view_alarm,
    input  logic             key_valid,
    input  logic [WIDTH-1:0] key_value,
    output logic [WIDTH-1:0] current_time,
    output logic [WIDTH-1:0] alarm_time,
    output logic             show_a,
    output logic             busy,
    output logic             key_error
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(ENTRY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        TIME_ENTRY  = 2'd1,
        ALARM_ENTRY = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [PW-1:0]    prescale_cnt, prescale_next;
    logic [TW-1:0]    timeout_cnt, timeout_next;
    logic [WIDTH-1:0] time_next, alarm_next;
    logic             error_next, show_next, busy_next;
    logic             key_ok, key_bad;

    assign key_ok  = key_valid && (key_value <= MAX_VAL);
    assign key_bad = key_valid && (key_value > MAX_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prescale_cnt <= '0;
            timeout_cnt  <= '0;
            current_time <= '0;
            alarm_time   <= MAX_VAL;
            show_a       <= 1'b0;
            busy         <= 1'b0;
            key_error    <= 1'b0;
        end else begin
            state        <= state_next;
            prescale_cnt <= prescale_next;
            timeout_cnt  <= timeout_next;
            current_time <= time_next;
            alarm_time   <= alarm_next;
            show_a       <= show_next;
            busy         <= busy_next;
            key_error    <= error_next;
        end
    end

    always_comb begin
        state_next    = state;
        prescale_next = prescale_cnt;
        timeout_next  = '0;
        time_next     = current_time;
        alarm_next    = alarm_time;
        error_next    = 1'b0;

        // The clock stands still while a new time is being keyed in.
        if (state == TIME_ENTRY) begin
            prescale_next = '0;
        end else if (prescale_cnt == PRE_LAST) begin
            prescale_next = '0;
            time_next     = (current_time == MAX_VAL) ? '0 : current_time + WIDTH'(1);
        end else begin
            prescale_next = prescale_cnt + PW'(1);
        end

        case (state)
            IDLE: begin
                if (set_time) begin
                    state_next = TIME_ENTRY;
                end else if (set_alarm) begin
                    state_next = ALARM_ENTRY;
                end
            end
            TIME_ENTRY, ALARM_ENTRY: begin
                if (key_ok) begin
                    if (state == TIME_ENTRY) begin
                        time_next = key_value;
                    end else begin
                        alarm_next = key_value;
                    end
                    state_next = IDLE;
                end else if (key_bad) begin
                    error_next = 1'b1;
                end else if (timeout_cnt == TMO_LAST) begin
                    state_next = IDLE;
                end else begin
                    timeout_next = timeout_cnt + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        show_next = (state_next == ALARM_ENTRY) || ((state_next == IDLE) && view_alarm);
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Bench for alarm_time_keeper: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the alarm-clock rules.
module tb_alarm_time_keeper;

    localparam int WIDTH         = 4;
    localparam int MAX_COUNT     = 9;
    localparam int PRESCALE      = 4;
    localparam int ENTRY_TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             set_time = 1'b0;
    logic             set_alarm = 1'b0;
    logic             view_alarm = 1'b0;
    logic             key_valid = 1'b0;
    logic [WIDTH-1:0] key_value = '0;
    logic [WIDTH-1:0] current_time;
    logic [WIDTH-1:0] alarm_time;
    logic             show_a;
    logic             busy;
    logic             key_error;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 = idle, 1 = entering time, 2 = entering alarm.
    int m_time, m_alarm, m_mode, m_since_tick, m_idle_cycles;
    int m_show, m_busy, m_err;
    int saved_time;

    alarm_time_keeper #(
        .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT),
        .PRESCALE(PRESCALE), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
        .view_alarm(view_alarm), .key_valid(key_valid), .key_value(key_value),
        .current_time(current_time), .alarm_time(alarm_time), .show_a(show_a),
        .busy(busy), .key_error(key_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int next_mode;
        if (reset) begin
            m_time = 0; m_alarm = MAX_COUNT; m_mode = 0;
            m_since_tick = 0; m_idle_cycles = 0;
            m_show = 0; m_busy = 0; m_err = 0;
            return;
        end
        next_mode = m_mode;
        m_err = 0;
        if (m_mode == 1) begin
            m_since_tick = 0;
        end else begin
            m_since_tick++;
            if (m_since_tick == PRESCALE) begin
                m_since_tick = 0;
                m_time = (m_time + 1) % (MAX_COUNT + 1);
            end
        end
        if (m_mode == 0) begin
            if (set_time) next_mode = 1;
            else if (set_alarm) next_mode = 2;
            m_idle_cycles = 0;
        end else if (key_valid && int'(key_value) <= MAX_COUNT) begin
            if (m_mode == 1) m_time = int'(key_value);
            else m_alarm = int'(key_value);
            next_mode = 0;
            m_idle_cycles = 0;
        end else if (key_valid) begin
            m_err = 1;
            m_idle_cycles = 0;
        end else if (m_idle_cycles == ENTRY_TIMEOUT - 1) begin
            next_mode = 0;
            m_idle_cycles = 0;
        end else begin
            m_idle_cycles++;
        end
        m_mode = next_mode;
        m_busy = (m_mode != 0) ? 1 : 0;
        m_show = (m_mode == 2 || (m_mode == 0 && view_alarm)) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("current_time", 32'(current_time), 32'(m_time));
        check("alarm_time", 32'(alarm_time), 32'(m_alarm));
        check("show_a", 32'(show_a), 32'(m_show));
        check("busy", 32'(busy), 32'(m_busy));
        check("key_error", 32'(key_error), 32'(m_err));
    endtask

    task automatic key(input int v);
        key_valid = 1'b1;
        key_value = WIDTH'(v);
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        step();
        step();
        check("reset_time", 32'(current_time), 32'd0);
        check("reset_alarm", 32'(alarm_time), 32'd9);
        reset = 1'b0;

        // Free-running count and wrap
        for (int i = 0; i < 36; i++) step();
        check("count_at_9", 32'(current_time), 32'd9);
        for (int i = 0; i < 4; i++) step();
        check("count_wrap", 32'(current_time), 32'd0);

        // Time entry with a frozen clock
        set_time = 1'b1;
        step();
        set_time = 1'b0;
        check("time_entry_busy", 32'(busy), 32'd1);
        saved_time = int'(current_time);
        for (int i = 0; i < 6; i++) step();
        check("time_frozen", 32'(current_time), 32'(saved_time));
        key(7);
        check("time_loaded", 32'(current_time), 32'd7);
        check("time_busy_clear", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("time_hold_7", 32'(current_time), 32'd7);
        step();
        check("time_tick_8", 32'(current_time), 32'd8);

        // Alarm entry with a rejected key then an accepted one
        set_alarm = 1'b1;
        step();
        set_alarm = 1'b0;
        check("alarm_show", 32'(show_a), 32'd1);
        check("alarm_busy", 32'(busy), 32'd1);
        key(12);
        check("bad_key_err", 32'(key_error), 32'd1);
        check("bad_key_busy", 32'(busy), 32'd1);
        step();
        check("err_one_cycle", 32'(key_error), 32'd0);
        key(3);
        check("alarm_loaded", 32'(alarm_time), 32'd3);
        check("alarm_show_clear", 32'(show_a), 32'd0);

        // Simultaneous requests and entry timeout
        set_time = 1'b1;
        set_alarm = 1'b1;
        step();
        set_time = 1'b0;
        set_alarm = 1'b0;
        check("both_show", 32'(show_a), 32'd0);
        check("both_busy", 32'(busy), 32'd1);
        saved_time = int'(current_time);
        for (int i = 0; i < 15; i++) step();
        check("timeout_still_busy", 32'(busy), 32'd1);
        step();
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_time", 32'(current_time), 32'(saved_time));
        check("timeout_alarm", 32'(alarm_time), 32'd3);

        // view_alarm level and ignored key in idle
        view_alarm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("view_show", 32'(show_a), 32'd1);
        end
        view_alarm = 1'b0;
        step();
        check("view_off", 32'(show_a), 32'd0);
        key(5);
        check("idle_key_ignored", 32'(alarm_time), 32'd3);

        // Reset in the middle of an alarm entry
        set_alarm = 1'b1;
        step();
        set_alarm = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_alarm", 32'(alarm_time), 32'd9);
        key(4);
        check("post_reset_key", 32'(alarm_time), 32'd9);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            set_time   = ($urandom_range(0, 15) == 0);
            set_alarm  = ($urandom_range(0, 15) == 0);
            view_alarm = ($urandom_range(0, 3) == 0);
            key_valid  = ($urandom_range(0, 9) == 0);
            key_value  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            step();
        end
        reset = 1'b0;
        set_time = 1'b0;
        set_alarm = 1'b0;
        key_valid = 1'b0;
        view_alarm = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
